// File: rtl/dmem_bridge_if.sv
// Interfaces for the data-memory bridge: the core-side EM/WB memory port and the
// word-aligned system bus. The bridge is the slave of the core port and the master of the bus.

interface dmem_core_if;
    logic [31:0] mem_addr;
    logic        mem_oe;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        mem_ready;

    modport master (
        output mem_addr,
        output mem_oe,
        output mem_wdata,
        output mem_we,
        input  mem_rdata,
        input  mem_valid,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_oe,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata,
        output mem_valid,
        output mem_ready
    );
endinterface

interface dmem_bus_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_gnt,
        input  bus_rvalid,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_gnt,
        output bus_rvalid,
        output bus_rdata
    );
endinterface

// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns right-aligned byte-addressed core accesses into word-aligned bus
// transactions; stores are posted through a 1-entry buffer, loads run as single split reads.

module dmem_bridge #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic       clk,
    input  logic       rst_n,
    dmem_core_if.slave core,
    dmem_bus_if.master bus,
    output logic       err_misalign,
    output logic       err_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD_REQ,
        RD_WAIT
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  off_q, off_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        valid_q, valid_d;
    logic        mis_q, mis_d;
    logic        tmo_q, tmo_d;

    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic [1:0]  acc_off;

    // Stores snap to their natural alignment; the byte lane offset follows the snapped address.
    always_comb begin
        is_half    = (core.mem_we == 4'b0011);
        is_word    = (core.mem_we == 4'b1111);
        acc_off    = core.mem_addr[1:0];
        misaligned = 1'b0;
        if (is_half) begin
            acc_off    = {core.mem_addr[1], 1'b0};
            misaligned = core.mem_addr[0];
        end else if (is_word) begin
            acc_off    = 2'b00;
            misaligned = |core.mem_addr[1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        valid_d = 1'b0;
        mis_d   = mis_q;
        tmo_d   = tmo_q;

        case (state_q)
            IDLE: begin
                if (core.mem_oe) begin
                    addr_d = {core.mem_addr[31:2], 2'b00};
                    if (core.mem_we != 4'b0000) begin
                        be_d    = core.mem_we << acc_off;
                        wdata_d = core.mem_wdata << {acc_off, 3'b000};
                        mis_d   = mis_q | misaligned;
                        state_d = WR;
                    end else begin
                        be_d    = 4'b1111;
                        off_d   = core.mem_addr[1:0];
                        state_d = RD_REQ;
                    end
                end
            end
            WR: begin
                if (bus.bus_gnt) begin
                    state_d = IDLE;
                end
            end
            RD_REQ: begin
                if (bus.bus_gnt) begin
                    cnt_d   = 8'd0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // A response arriving on the last permitted cycle still wins over the timeout.
                if (bus.bus_rvalid) begin
                    rdata_d = bus.bus_rdata >> {off_q, 3'b000};
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = ERR_DATA;
                    valid_d = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            off_q   <= 2'd0;
            cnt_q   <= 8'd0;
            rdata_q <= 32'd0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            tmo_q   <= tmo_d;
        end
    end

    assign core.mem_ready = (state_q == IDLE);
    assign core.mem_valid = valid_q;
    assign core.mem_rdata = rdata_q;

    // Request and direction come straight from the state so an async reset drops them at once.
    assign bus.bus_req   = (state_q == WR) || (state_q == RD_REQ);
    assign bus.bus_we    = (state_q == WR);
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;

    assign err_misalign = mis_q;
    assign err_timeout  = tmo_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: a random core driver, a random bus responder and a
// monitor that compares every bus grant and every mem_valid pulse against queued expectations.

module tb_dmem_bridge;

    localparam int          TMO  = 4;
    localparam logic [31:0] ERRV = 32'hDEADBEEF;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        mis;
    } bus_exp_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        logic        tmo;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_misalign;
    logic err_timeout;

    dmem_core_if cif ();
    dmem_bus_if  bif ();

    dmem_bridge #(
        .TIMEOUT (TMO),
        .ERR_DATA(ERRV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .core        (cif.slave),
        .bus         (bif.master),
        .err_misalign(err_misalign),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    bus_exp_t busQ[$];
    rd_exp_t  rdQ[$];
    int       offQ[$];

    int   gntMin = 0, gntMax = 0;
    int   rvMin = 1, rvMax = 1;
    bit   dropAllowed = 0;
    bit   forceDrop = 0;
    bit   lateMode = 0;
    bit   expMis = 0;
    bit   expTmo = 0;
    int   pendingLoads = 0;
    logic [31:0] lastRdata = 32'd0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference model: access size from the mask, natural alignment by rounding the offset down.
    task automatic pushExpected(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
        bus_exp_t        t;
        int              size;
        int              off;
        longint unsigned lane;
        size   = $countones(we);
        off    = int'(a % 4);
        t.addr = a - (a % 4);
        if (size == 0) begin
            t.we    = 1'b0;
            t.be    = 4'hF;
            t.wdata = 32'd0;
            offQ.push_back(off);
            pendingLoads++;
        end else begin
            off = off - (off % size);
            if ((a % size) != 0) expMis = 1'b1;
            t.we    = 1'b1;
            t.be    = 4'(((1 << size) - 1) << off);
            lane    = (longint'(wd) & ((64'd1 << (8 * size)) - 64'd1)) << (8 * off);
            t.wdata = lane[31:0];
        end
        t.mis = expMis;
        busQ.push_back(t);
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
        int waited = 0;
        forever begin
            @(negedge clk);
            cif.mem_oe    = 1'b1;
            cif.mem_addr  = a;
            cif.mem_we    = we;
            cif.mem_wdata = wd;
            if (cif.mem_ready) begin
                pushExpected(a, we, wd);
                break;
            end
            waited++;
            if (waited > 100) begin
                checkOutput("accept_wait_ready", cif.mem_ready, 1);
                cif.mem_oe = 1'b0;
                return;
            end
        end
        // The bridge is busy on the cycle after acceptance, so junk requests here must be ignored.
        @(negedge clk);
        cif.mem_oe    = 1'($urandom_range(0, 1));
        cif.mem_addr  = $urandom;
        cif.mem_we    = 4'($urandom);
        cif.mem_wdata = $urandom;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            cif.mem_oe    = 1'b0;
            cif.mem_addr  = $urandom;
            cif.mem_we    = 4'($urandom);
            cif.mem_wdata = $urandom;
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((busQ.size() != 0 || pendingLoads != 0) && n < 200) begin
            @(negedge clk);
            cif.mem_oe = 1'b0;
            n++;
        end
        checkOutput("drain_bus_queue", busQ.size(), 0);
        checkOutput("drain_pending_loads", pendingLoads, 0);
    endtask

    initial begin : responder
        int          gd;
        int          d;
        int          off;
        logic        isRead;
        int          gCyc;
        logic [31:0] data;
        rd_exp_t     r;
        bif.bus_gnt    = 1'b0;
        bif.bus_rvalid = 1'b0;
        bif.bus_rdata  = 32'd0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bif.bus_req === 1'b1) begin
                gd = $urandom_range(gntMax, gntMin);
                repeat (gd) @(negedge clk);
                isRead = !bif.bus_we;
                off    = 0;
                if (isRead && offQ.size() != 0) off = offQ.pop_front();
                bif.bus_gnt = 1'b1;
                gCyc        = cyc;
                @(negedge clk);
                bif.bus_gnt = 1'b0;
                if (isRead) begin
                    if (lateMode) begin
                        repeat (4) @(negedge clk);
                        bif.bus_rvalid = 1'b1;
                        bif.bus_rdata  = $urandom;
                        @(negedge clk);
                        bif.bus_rvalid = 1'b0;
                    end else if (forceDrop || (dropAllowed && $urandom_range(0, 7) == 0)) begin
                        forceDrop = 0;
                        expTmo    = 1'b1;
                        r.data    = ERRV;
                        r.cyc     = gCyc + TMO + 1;
                        r.tmo     = 1'b1;
                        rdQ.push_back(r);
                        repeat (TMO) @(negedge clk);
                        bif.bus_rvalid = 1'b1;
                        bif.bus_rdata  = $urandom;
                        @(negedge clk);
                        bif.bus_rvalid = 1'b0;
                    end else begin
                        d = $urandom_range(rvMax, rvMin);
                        repeat (d - 1) @(negedge clk);
                        data           = $urandom;
                        bif.bus_rvalid = 1'b1;
                        bif.bus_rdata  = data;
                        r.data = data >> (8 * off);
                        r.cyc  = cyc + 1;
                        r.tmo  = expTmo;
                        rdQ.push_back(r);
                        @(negedge clk);
                        bif.bus_rvalid = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : monitor
        bus_exp_t    t;
        rd_exp_t     r;
        logic [31:0] m;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n !== 1'b1) continue;
            if (bif.bus_req && bif.bus_gnt) begin
                if (busQ.size() == 0) begin
                    checkOutput("spurious_bus_txn", 1, 0);
                end else begin
                    t = busQ.pop_front();
                    checkOutput("bus_we", bif.bus_we, t.we);
                    checkOutput("bus_addr", bif.bus_addr, t.addr);
                    checkOutput("bus_be", bif.bus_be, t.be);
                    if (t.we) begin
                        m = 32'd0;
                        for (int i = 0; i < 4; i++) if (t.be[i]) m[8*i +: 8] = 8'hFF;
                        checkOutput("bus_wdata", bif.bus_wdata & m, t.wdata);
                    end
                    checkOutput("err_misalign", err_misalign, t.mis);
                end
            end
            if (cif.mem_valid) begin
                if (rdQ.size() == 0) begin
                    checkOutput("spurious_mem_valid", 1, 0);
                end else begin
                    r = rdQ.pop_front();
                    checkOutput("mem_rdata", cif.mem_rdata, r.data);
                    checkOutput("mem_valid_cycle", cyc, r.cyc);
                    checkOutput("err_timeout", err_timeout, r.tmo);
                    lastRdata = r.data;
                    pendingLoads--;
                end
            end else begin
                checkOutput("mem_rdata_hold", cif.mem_rdata, lastRdata);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [3:0] weSel [4];
        int         kind;
        weSel[0] = 4'b0000;
        weSel[1] = 4'b0001;
        weSel[2] = 4'b0011;
        weSel[3] = 4'b1111;

        cif.mem_oe    = 1'b0;
        cif.mem_addr  = 32'd0;
        cif.mem_we    = 4'd0;
        cif.mem_wdata = 32'd0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_mem_ready", cif.mem_ready, 1);
        checkOutput("rst_mem_valid", cif.mem_valid, 0);
        checkOutput("rst_mem_rdata", cif.mem_rdata, 0);
        checkOutput("rst_bus_req", bif.bus_req, 0);
        checkOutput("rst_bus_we", bif.bus_we, 0);
        checkOutput("rst_bus_addr", bif.bus_addr, 0);
        checkOutput("rst_bus_be", bif.bus_be, 0);
        checkOutput("rst_bus_wdata", bif.bus_wdata, 0);
        checkOutput("rst_err_misalign", err_misalign, 0);
        checkOutput("rst_err_timeout", err_timeout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idleCycles(2);

        $display("[TB] directed accesses");
        gntMin = 0; gntMax = 0; rvMin = 1; rvMax = 1;
        applyStimulus(32'h0000_0103, 4'b0001, 32'h0000_00A5);
        #1 checkOutput("sb_ready_busy", cif.mem_ready, 0);
        @(negedge clk);
        cif.mem_oe = 1'b0;
        #1 checkOutput("sb_ready_again", cif.mem_ready, 1);
        waitDrain();

        applyStimulus(32'h0000_0200, 4'b0000, 32'd0);
        waitDrain();
        applyStimulus(32'h0000_0202, 4'b0000, 32'd0);
        waitDrain();
        applyStimulus(32'h0000_0203, 4'b0011, 32'h1234_BEEF);
        waitDrain();
        checkOutput("sh_misalign_sticky", err_misalign, 1);

        gntMin = 3; gntMax = 3;
        applyStimulus(32'h0000_0204, 4'b1111, 32'hCAFE_F00D);
        applyStimulus(32'h0000_0204, 4'b0000, 32'd0);
        waitDrain();

        $display("[TB] load timeout");
        gntMin = 0; gntMax = 0;
        forceDrop = 1;
        applyStimulus(32'h0000_0300, 4'b0000, 32'd0);
        waitDrain();
        checkOutput("timeout_sticky", err_timeout, 1);
        idleCycles(3);

        $display("[TB] reset during read wait");
        lateMode = 1;
        applyStimulus(32'h0000_0400, 4'b0000, 32'd0);
        cif.mem_oe = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_bus_req", bif.bus_req, 0);
        checkOutput("arst_mem_ready", cif.mem_ready, 1);
        checkOutput("arst_mem_valid", cif.mem_valid, 0);
        checkOutput("arst_err_misalign", err_misalign, 0);
        checkOutput("arst_err_timeout", err_timeout, 0);
        expMis       = 1'b0;
        expTmo       = 1'b0;
        lastRdata    = 32'd0;
        pendingLoads = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idleCycles(8);
        lateMode = 0;

        $display("[TB] random traffic");
        gntMin = 0; gntMax = 3; rvMin = 1; rvMax = TMO;
        dropAllowed = 1;
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 3);
            applyStimulus($urandom, weSel[kind], $urandom);
            idleCycles($urandom_range(0, 2));
        end
        waitDrain();
        idleCycles(TMO + 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
